// File: rtl/wb_bus_arbiter_if.sv
// Wishbone classic point-to-point bus bundle used on each side of wb_bus_arbiter.
// The memory slave has no error output, so err is only driven toward masters.
interface wb_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, adr, dat_o, input dat_i, ack);
  modport slave  (input cyc, stb, we, adr, dat_o, output dat_i, ack, err);
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of a single slave.
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  wb_bus_arbiter_if.slave     m0,
  wb_bus_arbiter_if.slave     m1,
  wb_bus_arbiter_if.master    s,
  output logic [1:0]          gnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          req0, req1, timeout;
  logic [AW-1:0] adr_mux;
  logic [DW-1:0] dat_mux;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  logic [7:0] wd_q, wd_d;
  logic [1:0] blk_q, blk_d;

  assign timeout = (state_q != IDLE) && (wd_q == TO_LIMIT);
  // A master that timed out is locked out until it drops cyc.
  assign req0    = m0.cyc & ~blk_q[0];
  assign req1    = m1.cyc & ~blk_q[1];

  always_comb begin
    wd_d = wd_q;
    if ((state_d != state_q) || s.ack) wd_d = '0;
    else if (s.stb)                    wd_d = wd_q + 8'd1;
    blk_d = blk_q & {m1.cyc, m0.cyc};
    if (timeout) begin
      if (state_q == GNT0) blk_d[0] = m0.cyc;
      else                 blk_d[1] = m1.cyc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      blk_q <= '0;
    end else begin
      wd_q  <= wd_d;
      blk_q <= blk_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign req0           = m0.cyc;
  assign req1           = m1.cyc;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (req0 && (!req1 || last_q)) state_d = GNT0;
        else if (req1)                 state_d = GNT1;
      end
      GNT0: begin
        if (timeout) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (!m0.cyc) begin
          last_d  = 1'b0;
          state_d = req1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (timeout) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (!m1.cyc) begin
          last_d  = 1'b1;
          state_d = req0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    adr_mux  = '0;
    dat_mux  = '0;
    m0.ack   = 1'b0;
    m0.dat_i = '0;
    m1.ack   = 1'b0;
    m1.dat_i = '0;
    case (state_q)
      GNT0: begin
        s.cyc    = m0.cyc & ~timeout;
        s.stb    = m0.stb & ~timeout;
        s.we     = m0.we;
        adr_mux  = m0.adr;
        dat_mux  = m0.dat_o;
        m0.ack   = s.ack & ~timeout;
        m0.dat_i = s.dat_i;
      end
      GNT1: begin
        s.cyc    = m1.cyc & ~timeout;
        s.stb    = m1.stb & ~timeout;
        s.we     = m1.we;
        adr_mux  = m1.adr;
        dat_mux  = m1.dat_o;
        m1.ack   = s.ack & ~timeout;
        m1.dat_i = s.dat_i;
      end
      default: ;
    endcase
  end

  assign s.adr   = adr_mux;
  assign s.dat_o = dat_mux;
  assign m0.err  = timeout & (state_q == GNT0);
  assign m1.err  = timeout & (state_q == GNT1);
  assign gnt     = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: per-cycle vector table plus multi-cycle
// sequences for reset, tie alternation, bus lock and the watchdog option.
module tb_wb_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] gnt;
  int         n_chk = 0;
  int         n_fail = 0;

  wb_bus_arbiter_if #(.AW(16), .DW(8)) m0_if ();
  wb_bus_arbiter_if #(.AW(16), .DW(8)) m1_if ();
  wb_bus_arbiter_if #(.AW(16), .DW(8)) s_if ();

  assign s_if.err = 1'b0;

  wb_bus_arbiter #(.AW(16), .DW(8), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt   (gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m0c, m0s, m0w; logic [15:0] m0a; logic [7:0] m0d;
    logic m1c, m1s, m1w; logic [15:0] m1a; logic [7:0] m1d;
    logic sack; logic [7:0] sdat;
    logic [1:0] gnt; logic scyc, sstb, swe; logic [15:0] sadr; logic [7:0] sdo;
    logic m0ack, m1ack; logic [7:0] m0di, m1di;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_m0(input logic c, input logic s, input logic w, input logic [15:0] a, input logic [7:0] d);
    m0_if.cyc = c; m0_if.stb = s; m0_if.we = w; m0_if.adr = a; m0_if.dat_o = d;
  endtask

  task automatic drive_m1(input logic c, input logic s, input logic w, input logic [15:0] a, input logic [7:0] d);
    m1_if.cyc = c; m1_if.stb = s; m1_if.we = w; m1_if.adr = a; m1_if.dat_o = d;
  endtask

  task automatic drive_s(input logic ack, input logic [7:0] d);
    s_if.ack = ack; s_if.dat_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive_m1(1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive_s(1'b0, 8'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h00,8'h00};
    vecs[1]  = '{1'b1,1'b1,1'b1,16'h0012,8'hA5, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b01,1'b1,1'b1,1'b1,16'h0012,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    vecs[2]  = '{1'b1,1'b1,1'b1,16'h0012,8'hA5, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,8'h5A,
                 2'b01,1'b1,1'b1,1'b1,16'h0012,8'hA5, 1'b1,1'b0,8'h5A,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h00,8'h00};
    vecs[4]  = '{1'b1,1'b1,1'b0,16'h0100,8'h00, 1'b1,1'b1,1'b0,16'h0200,8'h00, 1'b0,8'h00,
                 2'b10,1'b1,1'b1,1'b0,16'h0200,8'h00, 1'b0,1'b0,8'h00,8'h00};
    vecs[5]  = '{1'b1,1'b1,1'b0,16'h0100,8'h00, 1'b1,1'b1,1'b0,16'h0200,8'h00, 1'b1,8'h3C,
                 2'b10,1'b1,1'b1,1'b0,16'h0200,8'h00, 1'b0,1'b1,8'h00,8'h3C};
    vecs[6]  = '{1'b1,1'b1,1'b0,16'h0100,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b01,1'b1,1'b1,1'b0,16'h0100,8'h00, 1'b0,1'b0,8'h00,8'h00};
    vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,1'b1,16'h0800,8'hC3, 1'b0,8'h00,
                 2'b10,1'b1,1'b1,1'b1,16'h0800,8'hC3, 1'b0,1'b0,8'h00,8'h00};
    vecs[8]  = '{1'b1,1'b1,1'b1,16'h0044,8'h11, 1'b1,1'b1,1'b1,16'h0800,8'hC3, 1'b1,8'h77,
                 2'b10,1'b1,1'b1,1'b1,16'h0800,8'hC3, 1'b0,1'b1,8'h00,8'h77};
    vecs[9]  = '{1'b1,1'b1,1'b1,16'h0044,8'h11, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b01,1'b1,1'b1,1'b1,16'h0044,8'h11, 1'b0,1'b0,8'h00,8'h00};
    vecs[10] = '{1'b1,1'b0,1'b1,16'h0044,8'h11, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b01,1'b1,1'b0,1'b1,16'h0044,8'h11, 1'b0,1'b0,8'h00,8'h00};
    vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,8'h00,
                 2'b00,1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h00,8'h00};

    // Reset held with master 0 requesting: nothing may be granted.
    reset = 1'b1;
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00);
    drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive_s(1'b0, 8'h00);
    step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_s_cyc", 32'(s_if.cyc), 32'h0);
    check("rst_s_stb", 32'(s_if.stb), 32'h0);
    check("rst_m0_ack", 32'(m0_if.ack), 32'h0);
    check("rst_m0_err", 32'(m0_if.err), 32'h0);
    check("rst_m0_dat_i", 32'(m0_if.dat_i), 32'h0);
    reset = 1'b0;
    step();
    check("rel_gnt", 32'(gnt), 32'h1);
    check("rel_s_cyc", 32'(s_if.cyc), 32'h1);

    // Per-cycle vector table.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_m0(vecs[i].m0c, vecs[i].m0s, vecs[i].m0w, vecs[i].m0a, vecs[i].m0d);
      drive_m1(vecs[i].m1c, vecs[i].m1s, vecs[i].m1w, vecs[i].m1a, vecs[i].m1d);
      drive_s(vecs[i].sack, vecs[i].sdat);
      step();
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_s_cyc", i), 32'(s_if.cyc), 32'(vecs[i].scyc));
      check($sformatf("v%0d_s_stb", i), 32'(s_if.stb), 32'(vecs[i].sstb));
      check($sformatf("v%0d_s_we", i), 32'(s_if.we), 32'(vecs[i].swe));
      check($sformatf("v%0d_s_adr", i), 32'(s_if.adr), 32'(vecs[i].sadr));
      check($sformatf("v%0d_s_dat_o", i), 32'(s_if.dat_o), 32'(vecs[i].sdo));
      check($sformatf("v%0d_m0_ack", i), 32'(m0_if.ack), 32'(vecs[i].m0ack));
      check($sformatf("v%0d_m1_ack", i), 32'(m1_if.ack), 32'(vecs[i].m1ack));
      check($sformatf("v%0d_m0_dat_i", i), 32'(m0_if.dat_i), 32'(vecs[i].m0di));
      check($sformatf("v%0d_m1_dat_i", i), 32'(m1_if.dat_i), 32'(vecs[i].m1di));
    end

    // Tie from reset goes to master 0, handover to master 1, second tie back to 0.
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0001, 8'h00);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0002, 8'h00);
    step();
    check("tie1_gnt", 32'(gnt), 32'h1);
    check("tie1_adr", 32'(s_if.adr), 32'h0001);
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    check("hand_gnt", 32'(gnt), 32'h2);
    check("hand_adr", 32'(s_if.adr), 32'h0002);
    drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    check("tie_idle_gnt", 32'(gnt), 32'h0);
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0001, 8'h00);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0002, 8'h00);
    step();
    check("tie2_gnt", 32'(gnt), 32'h1);
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive_m1(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();

    // Master 0 burst holds the bus while master 1 waits.
    drive_m0(1'b1, 1'b1, 1'b1, 16'h0010, 8'h55);
    step();
    check("lock_gnt0", 32'(gnt), 32'h1);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0800, 8'h00);
    for (int k = 0; k < 3; k++) begin
      drive_m0(1'b1, 1'b1, 1'b1, 16'h0010 + 16'(k), 8'h55);
      drive_s(1'b1, 8'h00);
      step();
      check($sformatf("lock%0d_gnt", k), 32'(gnt), 32'h1);
      check($sformatf("lock%0d_m0_ack", k), 32'(m0_if.ack), 32'h1);
      check($sformatf("lock%0d_m1_ack", k), 32'(m1_if.ack), 32'h0);
      check($sformatf("lock%0d_adr", k), 32'(s_if.adr), 32'h0010 + 32'(k));
    end
    drive_m0(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive_s(1'b0, 8'h00);
    step();
    check("lock_gnt1", 32'(gnt), 32'h2);
    check("lock_m1_adr", 32'(s_if.adr), 32'h0800);
    drive_s(1'b1, 8'h3C);
    #1;
    check("lock_m1_dat_i", 32'(m1_if.dat_i), 32'h3C);
    check("lock_m1_ack", 32'(m1_if.ack), 32'h1);
    check("lock_m0_dat_i", 32'(m0_if.dat_i), 32'h0);

    // Asynchronous reset during master 1's transfer.
    reset = 1'b1;
    #1;
    check("mid_rst_s_cyc", 32'(s_if.cyc), 32'h0);
    check("mid_rst_s_stb", 32'(s_if.stb), 32'h0);
    check("mid_rst_m1_ack", 32'(m1_if.ack), 32'h0);
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    step();

    // Slave never acks while master 1 waits.
    do_reset();
    drive_m0(1'b1, 1'b1, 1'b0, 16'h0020, 8'h00);
    drive_m1(1'b1, 1'b1, 1'b0, 16'h0030, 8'h00);
    step();
    check("to_gnt", 32'(gnt), 32'h1);
    check("to_err0", 32'(m0_if.err), 32'h0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("to_c%0d_err", c), 32'(m0_if.err), (c == 4) ? 32'h1 : 32'h0);
      check($sformatf("to_c%0d_s_cyc", c), 32'(s_if.cyc), (c == 4) ? 32'h0 : 32'h1);
      check($sformatf("to_c%0d_gnt", c), 32'(gnt), 32'h1);
    end
    check("to_s_stb", 32'(s_if.stb), 32'h0);
    step();
    check("to_idle_gnt", 32'(gnt), 32'h0);
    check("to_idle_err", 32'(m0_if.err), 32'h0);
    step();
    check("to_m1_gnt", 32'(gnt), 32'h2);
    check("to_m1_adr", 32'(s_if.adr), 32'h0030);
    check("to_m1_err", 32'(m1_if.err), 32'h0);
`else
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("hang_c%0d_gnt", c), 32'(gnt), 32'h1);
      check($sformatf("hang_c%0d_err", c), 32'(m0_if.err), 32'h0);
      check($sformatf("hang_c%0d_s_cyc", c), 32'(s_if.cyc), 32'h1);
    end
    check("hang_m1_ack", 32'(m1_if.ack), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
